// File: rtl/xil_dmem_fifo_pkg.sv
// xil_dmem_fifo_pkg: shared sizing helpers and the DH delay macro for sequential assignments
`ifndef XIL_DMEM_DH
`define XIL_DMEM_DH
`define DH
`endif
package xil_dmem_fifo_pkg;
  function automatic int depth_of(input int adr_w);
    return 1 << adr_w;
  endfunction
  function automatic int cnt_w(input int adr_w);
    return adr_w + 1;
  endfunction
endpackage

// File: rtl/xil_dmem_tp_param.sv
// xil_dmem_tp_param: DATA_W x 2**ADR_W distributed two-port RAM, sync write, async read
module xil_dmem_tp_param
  import xil_dmem_fifo_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADR_W  = 6
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADR_W-1:0]  wr_adr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADR_W-1:0]  rd_adr,
  output logic [DATA_W-1:0] rd_data
);
  localparam int DEPTH = depth_of(ADR_W);
  (* ram_style = "distributed" *) logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_adr] <= `DH wr_data;
  end
  assign rd_data = mem[rd_adr];
endmodule

// File: rtl/xil_dmem_fifo.sv
// xil_dmem_fifo: show-ahead single-clock FIFO on distributed RAM with occupancy, almost flags and sticky overflow/underflow
module xil_dmem_fifo
  import xil_dmem_fifo_pkg::*;
#(
  parameter int DATA_W        = 16,
  parameter int ADR_W         = 6,
  parameter int AFULL_MARGIN  = 2,
  parameter int AEMPTY_MARGIN = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_almost_full,
  output logic              o_almost_empty,
  output logic [ADR_W:0]    o_count,
  input  logic              i_clr_err,
  output logic              o_overflow,
  output logic              o_underflow
);
  localparam int DEPTH = depth_of(ADR_W);
  localparam int CW    = cnt_w(ADR_W);
  logic [ADR_W-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]    count, count_nxt;
  logic             push_ok, pop_ok;
  always_comb begin
    push_ok   = i_wr_en & (~o_full | i_rd_en);
    pop_ok    = i_rd_en & ~o_empty;
    count_nxt = count + CW'(push_ok) - CW'(pop_ok);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      o_full         <= 1'b0;
      o_empty        <= 1'b1;
      o_almost_full  <= 1'b0;
      o_almost_empty <= 1'b1;
      o_overflow     <= 1'b0;
      o_underflow    <= 1'b0;
    end else begin
      wr_ptr         <= `DH push_ok ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr         <= `DH pop_ok ? rd_ptr + 1'b1 : rd_ptr;
      count          <= `DH count_nxt;
      o_full         <= `DH count_nxt == CW'(DEPTH);
      o_empty        <= `DH count_nxt == '0;
      o_almost_full  <= `DH count_nxt >= CW'(DEPTH - AFULL_MARGIN);
      o_almost_empty <= `DH count_nxt <= CW'(AEMPTY_MARGIN);
      o_overflow     <= `DH (i_wr_en & ~push_ok) | (o_overflow & ~i_clr_err);
      o_underflow    <= `DH (i_rd_en & ~pop_ok) | (o_underflow & ~i_clr_err);
    end
  end
  assign o_count = count;
  xil_dmem_tp_param #(.DATA_W(DATA_W), .ADR_W(ADR_W)) u_ram (
    .clk     (clk),
    .wr_en   (push_ok),
    .wr_adr  (wr_ptr),
    .wr_data (i_wr_data),
    .rd_adr  (rd_ptr),
    .rd_data (o_rd_data)
  );
endmodule

// File: tb/tb_xil_dmem_fifo.sv
// tb_xil_dmem_fifo: scenario tasks plus random traffic against a queue-based FIFO model
module tb_xil_dmem_fifo;
  localparam int DW = 16, AW = 4, DEPTH = 16, AFM = 2, AEM = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  logic wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
  logic [DW-1:0] wr_data = '0, rd_data;
  logic full, empty, afull, aempty, ovf, udf;
  logic [AW:0] count;
  int n_tests = 0, n_fail = 0;
  logic [DW-1:0] q[$];
  logic m_ovf = 1'b0, m_udf = 1'b0;

  xil_dmem_fifo #(.DATA_W(DW), .ADR_W(AW), .AFULL_MARGIN(AFM), .AEMPTY_MARGIN(AEM)) dut (
    .clk(clk), .rst_n(rst_n), .i_wr_en(wr_en), .i_wr_data(wr_data), .i_rd_en(rd_en),
    .o_rd_data(rd_data), .o_full(full), .o_empty(empty), .o_almost_full(afull),
    .o_almost_empty(aempty), .o_count(count), .i_clr_err(clr_err),
    .o_overflow(ovf), .o_underflow(udf));

  always #5 clk = ~clk;

  // drives one cycle, advances the model, returns at posedge+1
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
    bit push_ok, pop_ok;
    wr_en = w; wr_data = d; rd_en = r; clr_err = c;
    push_ok = w && (q.size() < DEPTH || r);
    pop_ok  = r && q.size() > 0;
    @(posedge clk);
    if (pop_ok) void'(q.pop_front());
    if (push_ok) q.push_back(d);
    m_ovf = (w && !push_ok) || (m_ovf && !c);
    m_udf = (r && !pop_ok) || (m_udf && !c);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; #12; q.delete(); m_ovf = 0; m_udf = 0;
    n_tests++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
    n_tests++; if ({empty, aempty, full, afull, ovf, udf} !== 6'b110000) begin n_fail++;
      $display("FAIL reset_flags got %b exp 110000", {empty, aempty, full, afull, ovf, udf}); end
    @(negedge clk); rst_n = 1'b1; @(posedge clk); #1;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= DEPTH; i++) begin
      step(1, DW'(i), 0, 0);
      n_tests++; if (count !== 5'(i) || empty !== 1'b0) begin n_fail++;
        $display("FAIL fill_count got %0d/%b exp %0d/0", count, empty, i); end
      n_tests++; if (afull !== (i >= DEPTH - AFM) || full !== (i == DEPTH)) begin n_fail++;
        $display("FAIL fill_flags at %0d got afull=%b full=%b", i, afull, full); end
    end
    n_tests++; if (rd_data !== 16'h0001) begin n_fail++; $display("FAIL fill_head got %h exp 0001", rd_data); end
  endtask

  task automatic test_overflow_drain();
    step(1, 16'hBEEF, 0, 0);
    n_tests++; if (ovf !== 1'b1 || count !== 5'd16) begin n_fail++;
      $display("FAIL ovf got ovf=%b count=%0d exp 1/16", ovf, count); end
    for (int i = 1; i <= DEPTH; i++) begin
      n_tests++; if (rd_data !== DW'(i)) begin n_fail++; $display("FAIL drain_data got %h exp %h", rd_data, DW'(i)); end
      step(0, '0, 1, 0);
      n_tests++; if (aempty !== (DEPTH - i <= AEM) || empty !== (i == DEPTH)) begin n_fail++;
        $display("FAIL drain_flags at %0d got aempty=%b empty=%b", DEPTH - i, aempty, empty); end
    end
    step(0, '0, 0, 1);
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b exp 0", ovf); end
  endtask

  task automatic test_underflow();
    step(1, 16'h1234, 1, 0);
    n_tests++; if (udf !== 1'b1 || count !== 5'd1 || rd_data !== 16'h1234) begin n_fail++;
      $display("FAIL udf_push got udf=%b count=%0d data=%h exp 1/1/1234", udf, count, rd_data); end
    step(0, '0, 1, 1);
    n_tests++; if (udf !== 1'b0 || empty !== 1'b1) begin n_fail++;
      $display("FAIL udf_pop_clr got udf=%b empty=%b exp 0/1", udf, empty); end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] d;
    for (int i = 0; i < DEPTH; i++) step(1, DW'($urandom), 0, 0);
    for (int i = 0; i < 40; i++) begin
      d = DW'($urandom);
      n_tests++; if (rd_data !== q[0]) begin n_fail++; $display("FAIL wrap_data got %h exp %h", rd_data, q[0]); end
      step(1, d, 1, 0);
      n_tests++; if (full !== 1'b1 || ovf !== 1'b0 || count !== 5'd16) begin n_fail++;
        $display("FAIL wrap_flags got full=%b ovf=%b count=%0d", full, ovf, count); end
    end
    while (q.size() > 0) begin
      n_tests++; if (rd_data !== q[0]) begin n_fail++; $display("FAIL wrap_drain got %h exp %h", rd_data, q[0]); end
      step(0, '0, 1, 0);
    end
  endtask

  task automatic test_clr_err();
    step(0, '0, 1, 1);
    n_tests++; if (udf !== 1'b1) begin n_fail++; $display("FAIL clr_vs_err got %b exp 1", udf); end
    step(0, '0, 0, 1);
    n_tests++; if (udf !== 1'b0) begin n_fail++; $display("FAIL clr_alone got %b exp 0", udf); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 7; i++) step(1, DW'($urandom), 0, 0);
    step(1, 16'h0, 1, 0);
    step(0, '0, 1, 0);
    step(1, 16'h0, 0, 0);
    n_tests++; if (count !== 5'd7) begin n_fail++; $display("FAIL pre_rst_count got %0d exp 7", count); end
    #2; rst_n = 1'b0; #1;
    q.delete(); m_ovf = 0; m_udf = 0;
    n_tests++; if (count !== 5'd0 || {empty, aempty, full, afull, ovf, udf} !== 6'b110000) begin n_fail++;
      $display("FAIL async_rst got count=%0d flags=%b exp 0/110000", count, {empty, aempty, full, afull, ovf, udf}); end
    #1; rst_n = 1'b1;
    @(posedge clk); #1;
    step(1, 16'hA5A5, 0, 0);
    n_tests++; if (rd_data !== 16'hA5A5 || count !== 5'd1) begin n_fail++;
      $display("FAIL post_rst got %h/%0d exp a5a5/1", rd_data, count); end
    step(0, '0, 1, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 9) < (i < 200 ? 6 : 4)), DW'($urandom),
           1'($urandom_range(0, 9) < (i < 200 ? 4 : 6)), 1'($urandom_range(0, 9) == 0));
      n_tests++; if (count !== 5'(q.size())) begin n_fail++; $display("FAIL rand_count got %0d exp %0d", count, q.size()); end
      n_tests++; if ({full, empty, afull, aempty} !== {q.size() == DEPTH, q.size() == 0, q.size() >= DEPTH - AFM, q.size() <= AEM}) begin
        n_fail++; $display("FAIL rand_flags got %b at count %0d", {full, empty, afull, aempty}, q.size()); end
      n_tests++; if (ovf !== m_ovf || udf !== m_udf) begin n_fail++;
        $display("FAIL rand_err got %b%b exp %b%b", ovf, udf, m_ovf, m_udf); end
      if (q.size() > 0) begin
        n_tests++; if (rd_data !== q[0]) begin n_fail++; $display("FAIL rand_data got %h exp %h", rd_data, q[0]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow_drain();
    test_underflow();
    test_wrap();
    test_clr_err();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/xil_dmem_fifo.md
Name: xil_dmem_fifo

Overview:
- Parametrised single-clock FIFO built on a generic two-port distributed (LUT) RAM; successor to the fixed 64x16 two-port memory.
- Adds occupancy tracking, full/empty/almost flags, guarded push/pop and sticky overflow/underflow error flags.
- Used for short buffering between tile-local blocks, e.g. network-interface and mailbox queues, where block RAM is too coarse.
- Read data is show-ahead: the head word is always presented combinationally while not empty.

Parameters:
- DATA_W, 16, data word width in bits (>=1).
- ADR_W, 6, address width; DEPTH = 2**ADR_W entries (ADR_W >= 2).
- AFULL_MARGIN, 2, o_almost_full asserts when count >= DEPTH - AFULL_MARGIN (1..DEPTH-1).
- AEMPTY_MARGIN, 2, o_almost_empty asserts when count <= AEMPTY_MARGIN (1..DEPTH-1).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_wr_en  in  1  push request.
- i_wr_data  in  DATA_W  push data.
- i_rd_en  in  1  pop request (acknowledges the current o_rd_data).
- o_rd_data  out  DATA_W  head-of-queue word; valid only while o_empty=0.
- o_full  out  1  count == DEPTH.
- o_empty  out  1  count == 0.
- o_almost_full  out  1  see AFULL_MARGIN.
- o_almost_empty  out  1  see AEMPTY_MARGIN.
- o_count  out  ADR_W+1  current occupancy, 0..DEPTH.
- i_clr_err  in  1  synchronous clear of the sticky error flags.
- o_overflow  out  1  sticky: a push was rejected.
- o_underflow  out  1  sticky: a pop was rejected.

Behaviour:
- Reset (rst_n=0, async): wr_ptr=rd_ptr=0, count=0; o_empty=1, o_almost_empty=1, o_full=0, o_almost_full=0, o_overflow=0, o_underflow=0. RAM contents are not reset; o_rd_data is don't-care while empty.
- Pointers are ADR_W bits and wrap naturally from DEPTH-1 to 0. Count is held in a separate ADR_W+1-bit register.
- push_ok = i_wr_en & (~o_full | i_rd_en): a push while full is accepted only together with a pop.
- pop_ok = i_rd_en & ~o_empty: a pop while empty is always rejected, including a simultaneous push, because there is no bypass.
- On push_ok: mem[wr_ptr] <= i_wr_data; wr_ptr++.
- On pop_ok: rd_ptr++.
- count update: count + push_ok - pop_ok. Both accepted leaves count unchanged, including when full.
- Rejected push (i_wr_en & ~push_ok): o_overflow <= 1. Rejected pop (i_rd_en & ~pop_ok): o_underflow <= 1.
- Error flags remain set until i_clr_err. If i_clr_err and a new error occur in the same cycle, the new error wins (flag stays 1).
- Latency: a word pushed in cycle n appears on o_rd_data, with o_empty=0, in cycle n+1. After a pop in cycle n, the next word is on o_rd_data in cycle n+1.
- RAM read is asynchronous: o_rd_data = mem[rd_ptr]. All flags are registered or decoded from the registered count; there is no combinational path from i_wr_en or i_rd_en to any flag.
- Flags are derived from the next-state count and registered with it, so they are never a cycle stale.
- Reset mid-operation discards all queued data immediately; the first push after release is read back correctly.

Decomposition:
- Shared package/header: DEPTH derivation (1<<ADR_W), count width (ADR_W+1), and the standard `dh delay macro used on sequential assignments.
- Sub-module: xil_dmem_tp_param.
  - Generic DATA_W x 2**ADR_W distributed two-port RAM with ram_style="distributed".
  - Synchronous write port (clk, wr_en, wr_adr, wr_data) and asynchronous read port.
  - Instantiated once, with the write enable driven by push_ok.
- The FIFO top holds the pointers, count, flags and error logic.

Test Plan (DATA_W=16, ADR_W=4, DEPTH=16, margins=2):
- Reset then push 0x0001..0x0010 on consecutive cycles -> o_empty falls 1 cycle after the first push; o_almost_full at count 14; o_full at count 16; o_count=16; o_rd_data=0x0001.
- From full, push 0xBEEF alone -> o_overflow=1, o_count stays 16. Then pop 16 times -> data 0x0001..0x0010 in order, o_empty=1, o_almost_empty from count 2.
- From empty, simultaneous push 0x1234 + pop -> o_underflow=1, o_count=1, o_rd_data=0x1234 next cycle.
- From full, simultaneous push 0x5555 + pop every cycle for 40 cycles -> o_full stays 1, no overflow; pointers wrap and order is preserved (last 16 pops return the last 16 pushes).
- Assert i_clr_err in the same cycle as a rejected pop -> o_underflow stays 1; i_clr_err alone on the next cycle -> 0.
- Async reset mid-stream with count=7 -> all flags return to reset values without a clock edge; a subsequent push of 0xA5A5 is read back as 0xA5A5.
